// File: rtl/turbo_pkg.sv
// Shared sizing, state encoding and lane-wrap helper for the turbo lane dispatcher.
package turbo_pkg;

  localparam int NUM_TURBO = 16;
  localparam int NUM_BEATS = 25;
  localparam int SELW      = $clog2(NUM_TURBO);
  localparam int CNTW      = $clog2(NUM_BEATS);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCK   = 1'b1
  } sched_state_t;

  function automatic logic [SELW-1:0] next_lane(input logic [SELW-1:0] lane);
    if (lane == SELW'(NUM_TURBO - 1)) return '0;
    return lane + 1'b1;
  endfunction

endpackage

// File: rtl/turbo_rr_pick.sv
// Rotating-priority encoder: first set req bit at or after start, wrapping past the top lane.
module turbo_rr_pick
  import turbo_pkg::*;
(
  input  logic [NUM_TURBO-1:0] req,
  input  logic [SELW-1:0]      start,
  output logic                 found,
  output logic [SELW-1:0]      idx
);

  // Scan from the farthest offset down so the nearest hit is written last and wins.
  always_comb begin
    found = 1'b0;
    idx   = start;
    for (int k = NUM_TURBO - 1; k >= 0; k--) begin
      int p;
      p = int'(start) + k;
      if (p >= NUM_TURBO) p = p - NUM_TURBO;
      if (req[SELW'(p)]) begin
        found = 1'b1;
        idx   = SELW'(p);
      end
    end
  end

endmodule

// File: rtl/turbo_dispatch_sched.sv
// Locks one ready, enabled decoder lane per turbo packet (round-robin) and forwards
// that packet's bus beats to it as a registered one-hot enable.
//
//   state  | meaning
//   SEARCH | no lane locked; pick next ready+enabled lane after last_grant
//   LOCK   | lane dec_sel owns the bus until NUM_BEATS beats have been forwarded
module turbo_dispatch_sched
  import turbo_pkg::*;
(
  input  logic                 clk_bus,
  input  logic                 rst_n,
  input  logic                 bus_en,
  output logic                 bus_ready,
  input  logic [NUM_TURBO-1:0] dec_ready,
  input  logic [NUM_TURBO-1:0] cfg_mask,
  output logic [NUM_TURBO-1:0] dec_en,
  output logic [SELW-1:0]      dec_sel,
  output logic                 pkt_done,
  output logic [31:0]          pkt_cnt,
  output logic                 err_beat
);

  sched_state_t   state;
  logic [CNTW-1:0] beat_cnt;
  logic [SELW-1:0] last_grant;

  logic            cand_found;
  logic [SELW-1:0] cand_idx;
  logic            last_beat;
  logic [NUM_TURBO-1:0] sel_onehot;

  turbo_rr_pick u_pick (
    .req   (dec_ready & ~cfg_mask),
    .start (next_lane(last_grant)),
    .found (cand_found),
    .idx   (cand_idx)
  );

  assign last_beat  = bus_en && (beat_cnt == CNTW'(NUM_BEATS - 1));
  assign sel_onehot = {{(NUM_TURBO-1){1'b0}}, 1'b1} << dec_sel;

  always_ff @(posedge clk_bus) begin
    if (!rst_n) begin
      state      <= SEARCH;
      beat_cnt   <= '0;
      last_grant <= SELW'(NUM_TURBO - 1);
      dec_sel    <= '0;
      bus_ready  <= 1'b0;
      dec_en     <= '0;
      pkt_done   <= 1'b0;
      pkt_cnt    <= '0;
      err_beat   <= 1'b0;
    end else begin
      case (state)
        SEARCH: begin
          dec_en   <= '0;
          pkt_done <= 1'b0;
          if (bus_en) err_beat <= 1'b1;
          if (cand_found) begin
            dec_sel   <= cand_idx;
            bus_ready <= 1'b1;
            state     <= LOCK;
          end else begin
            bus_ready <= 1'b0;
          end
        end
        LOCK: begin
          // bus_en alone marks a beat: upstream may still send one beat after ready falls.
          dec_en    <= bus_en ? sel_onehot : '0;
          pkt_done  <= last_beat;
          bus_ready <= dec_ready[dec_sel] && !last_beat;
          if (last_beat) begin
            beat_cnt   <= '0;
            last_grant <= dec_sel;
            pkt_cnt    <= pkt_cnt + 32'd1;
            state      <= SEARCH;
          end else if (bus_en) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_turbo_dispatch_sched.sv
// Directed bench for turbo_dispatch_sched: table of grant scenarios plus stall, error and reset sequences.
module tb_turbo_dispatch_sched;
  import turbo_pkg::*;

  logic                 clk_bus;
  logic                 rst_n;
  logic                 bus_en;
  logic                 bus_ready;
  logic [NUM_TURBO-1:0] dec_ready;
  logic [NUM_TURBO-1:0] cfg_mask;
  logic [NUM_TURBO-1:0] dec_en;
  logic [SELW-1:0]      dec_sel;
  logic                 pkt_done;
  logic [31:0]          pkt_cnt;
  logic                 err_beat;

  turbo_dispatch_sched dut (
    .clk_bus   (clk_bus),
    .rst_n     (rst_n),
    .bus_en    (bus_en),
    .bus_ready (bus_ready),
    .dec_ready (dec_ready),
    .cfg_mask  (cfg_mask),
    .dec_en    (dec_en),
    .dec_sel   (dec_sel),
    .pkt_done  (pkt_done),
    .pkt_cnt   (pkt_cnt),
    .err_beat  (err_beat)
  );

  initial begin
    clk_bus = 1'b0;
    forever #5 clk_bus = ~clk_bus;
  end

  typedef struct {
    logic [15:0] ready;
    logic [15:0] mask;
    int          npkt;
    int          g0;
    int          g1;
    int          g2;
  } vec_t;

  vec_t vecs[8];

  int n_chk;
  int n_fail;
  int lane_cnt[NUM_TURBO];
  int done_cnt;
  int cyc;
  int last_done;
  bit auto_en;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NUM_TURBO; i++) lane_cnt[i] = 0;
    done_cnt  = 0;
    last_done = -1;
  endtask

  // One clock: sample #1 after the edge, update monitors, then drive the next beat.
  task automatic step();
    @(posedge clk_bus);
    #1;
    cyc++;
    for (int i = 0; i < NUM_TURBO; i++) if (dec_en[i]) lane_cnt[i]++;
    if (pkt_done) begin
      done_cnt++;
      if (last_done >= 0) chk("pkt_gap_cycles", cyc - last_done, NUM_BEATS + 1);
      last_done = cyc;
    end
    chk("dec_en_onehot0", int'($onehot0(dec_en)), 1);
    if (auto_en) bus_en = bus_ready;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus_en  = 1'b0;
    auto_en = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    clear_counts();
  endtask

  task automatic run_pkts(input int n);
    int target;
    target    = done_cnt + n;
    last_done = -1;
    auto_en   = 1'b1;
    bus_en    = bus_ready;
    for (int t = 0; t < n * (NUM_BEATS + 4) + 20; t++) begin
      step();
      if (done_cnt >= target) break;
    end
    if (done_cnt < target) chk("run_pkts_timeout", done_cnt, target);
    auto_en = 1'b0;
    bus_en  = 1'b0;
  endtask

  task automatic wait_ready();
    for (int t = 0; t < 10 && !bus_ready; t++) step();
    chk("wait_bus_ready", int'(bus_ready), 1);
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    cyc     = 0;
    auto_en = 1'b0;
    rst_n   = 1'b0;
    bus_en  = 1'b0;
    dec_ready = '0;
    cfg_mask  = '0;
    clear_counts();

    vecs[0] = '{16'hFFFF, 16'h0000, 3, 0, 1, 2};
    vecs[1] = '{16'hFFFF, 16'h00FF, 2, 8, 9, 0};
    vecs[2] = '{16'h8001, 16'h0000, 2, 0, 15, 0};
    vecs[3] = '{16'h8000, 16'h0000, 2, 15, 15, 0};
    vecs[4] = '{16'hFFFF, 16'h7FFF, 2, 15, 15, 0};
    vecs[5] = '{16'h0030, 16'h0010, 2, 5, 5, 0};
    vecs[6] = '{16'hFFFF, 16'hFFFE, 2, 0, 0, 0};
    vecs[7] = '{16'h0F00, 16'h0100, 3, 9, 10, 11};

    // Reset state
    step();
    step();
    chk("rst_bus_ready", int'(bus_ready), 0);
    chk("rst_dec_en",    int'(dec_en),    0);
    chk("rst_dec_sel",   int'(dec_sel),   0);
    chk("rst_pkt_done",  int'(pkt_done),  0);
    chk("rst_pkt_cnt",   int'(pkt_cnt),   0);
    chk("rst_err_beat",  int'(err_beat),  0);

    // Table-driven grant scenarios
    foreach (vecs[v]) begin
      do_reset();
      dec_ready = vecs[v].ready;
      cfg_mask  = vecs[v].mask;
      run_pkts(vecs[v].npkt);
      for (int i = 0; i < NUM_TURBO; i++) begin
        int exp;
        exp = 0;
        if (vecs[v].g0 == i) exp += NUM_BEATS;
        if (vecs[v].npkt > 1 && vecs[v].g1 == i) exp += NUM_BEATS;
        if (vecs[v].npkt > 2 && vecs[v].g2 == i) exp += NUM_BEATS;
        chk($sformatf("vec%0d_lane%0d_beats", v, i), lane_cnt[i], exp);
      end
      chk($sformatf("vec%0d_pkt_cnt", v), int'(pkt_cnt), vecs[v].npkt);
      chk($sformatf("vec%0d_pkt_done", v), done_cnt, vecs[v].npkt);
    end

    // Single ready lane, then waits in SEARCH, then search resumes after lane 2
    do_reset();
    dec_ready = 16'h0004;
    run_pkts(1);
    chk("rdy_first_lane2", lane_cnt[2], NUM_BEATS);
    dec_ready = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rdy_wait_bus_ready", int'(bus_ready), 0);
    end
    dec_ready = 16'h0204;
    step();
    chk("rdy_grant_sel9", int'(dec_sel), 9);
    chk("rdy_grant_ready", int'(bus_ready), 1);
    run_pkts(1);
    chk("rdy_lane9_beats", lane_cnt[9], NUM_BEATS);
    chk("rdy_pkt_cnt", int'(pkt_cnt), 2);

    // Lane 0 loses ready after 10 beats; lock and beat count hold
    do_reset();
    dec_ready = 16'hFFFF;
    wait_ready();
    bus_en = 1'b1;
    repeat (10) step();
    bus_en    = 1'b0;
    dec_ready = 16'hFFFE;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_bus_ready", int'(bus_ready), 0);
      chk("stall_dec_en", int'(dec_en), 0);
    end
    chk("stall_beat_cnt", int'(dut.beat_cnt), 10);
    chk("stall_dec_sel", int'(dec_sel), 0);
    dec_ready = 16'hFFFF;
    run_pkts(1);
    chk("stall_lane0_beats", lane_cnt[0], NUM_BEATS);
    chk("stall_lane1_beats", lane_cnt[1], 0);
    chk("stall_pkt_cnt", int'(pkt_cnt), 1);

    // Beats in SEARCH with every lane masked
    do_reset();
    dec_ready = 16'hFFFF;
    cfg_mask  = 16'hFFFF;
    bus_en    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("err_dec_en", int'(dec_en), 0);
      chk("err_bus_ready", int'(bus_ready), 0);
    end
    chk("err_beat_set", int'(err_beat), 1);
    chk("err_pkt_cnt", int'(pkt_cnt), 0);
    bus_en   = 1'b0;
    cfg_mask = 16'h0000;
    step();
    step();
    chk("err_beat_sticky", int'(err_beat), 1);
    chk("err_then_lock", int'(bus_ready), 1);

    // Reset mid-packet at beat 12
    do_reset();
    dec_ready = 16'hFFFF;
    wait_ready();
    bus_en = 1'b1;
    repeat (12) step();
    rst_n = 1'b0;
    step();
    chk("midrst_bus_ready", int'(bus_ready), 0);
    chk("midrst_dec_en",    int'(dec_en),    0);
    chk("midrst_dec_sel",   int'(dec_sel),   0);
    chk("midrst_pkt_done",  int'(pkt_done),  0);
    chk("midrst_pkt_cnt",   int'(pkt_cnt),   0);
    chk("midrst_err_beat",  int'(err_beat),  0);
    rst_n  = 1'b1;
    bus_en = 1'b0;
    clear_counts();
    step();
    chk("midrst_grant_sel0", int'(dec_sel), 0);
    chk("midrst_grant_ready", int'(bus_ready), 1);
    run_pkts(1);
    chk("midrst_lane0_beats", lane_cnt[0], NUM_BEATS);
    chk("midrst_pkt_cnt_after", int'(pkt_cnt), 1);
    chk("midrst_pkt_done_cnt", done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
